// File: rtl/uart_frame_tx_ctrl.sv
// Frame transmit sequencer: header, length field, BRAM payload and a mod-256
// checksum, handed byte by byte to a UART transmitter via Tx_DV/Tx_Byte.
module uart_frame_tx_ctrl #(
    parameter int          ADDR_W    = 16,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input  logic              Clock,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] length,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    input  logic [7:0]        mem_rdata,
    output logic              Tx_DV,
    output logic [7:0]        Tx_Byte,
    input  logic              Tx_Active,
    input  logic              Tx_Done,
    output logic              busy,
    output logic              done,
    output logic [7:0]        checksum
);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_LOAD_HDR = 3'd1;
    localparam logic [2:0] ST_ISSUE    = 3'd2;
    localparam logic [2:0] ST_WAIT     = 3'd3;
    localparam logic [2:0] ST_FETCH    = 3'd4;
    localparam logic [2:0] ST_RDWAIT   = 3'd5;
    localparam logic [2:0] ST_LOAD_CS  = 3'd6;
    localparam logic [2:0] ST_FINISH   = 3'd7;

    // Which kind of byte is currently on the wire, so WAIT knows what just completed.
    localparam logic [1:0] KIND_HDR  = 2'd0;
    localparam logic [1:0] KIND_DATA = 2'd1;
    localparam logic [1:0] KIND_CS   = 2'd2;

    logic [2:0]        state_reg,    state_next;
    logic [1:0]        kind_reg,     kind_next;
    logic [1:0]        hdr_idx_reg,  hdr_idx_next;
    logic [ADDR_W-1:0] addr_reg,     addr_next;
    logic [ADDR_W-1:0] remain_reg,   remain_next;
    logic [ADDR_W-1:0] len_reg,      len_next;
    logic [7:0]        cs_reg,       cs_next;
    logic [7:0]        tx_byte_reg,  tx_byte_next;
    logic              tx_dv_reg,    tx_dv_next;
    logic              rd_en_reg,    rd_en_next;
    logic              busy_reg,     busy_next;
    logic              done_reg,     done_next;
    logic              tx_done_prev_reg;

    logic [15:0]       len16;
    logic [7:0]        hdr_byte;
    logic              tx_complete;
    logic              unused_tx_active;

    // Sequencing keys off Tx_Done alone; the busy flag is not needed.
    assign unused_tx_active = Tx_Active;

    // Only the first high cycle of the two-cycle Tx_Done counts as completion.
    assign tx_complete = Tx_Done & ~tx_done_prev_reg;

    always_comb begin
        len16             = 16'h0000;
        len16[ADDR_W-1:0] = len_reg;
    end

    always_comb begin
        case (hdr_idx_reg)
            2'd0:    hdr_byte = SYNC_BYTE;
            2'd1:    hdr_byte = len16[15:8];
            default: hdr_byte = len16[7:0];
        endcase
    end

    always_comb begin
        state_next   = state_reg;
        kind_next    = kind_reg;
        hdr_idx_next = hdr_idx_reg;
        addr_next    = addr_reg;
        remain_next  = remain_reg;
        len_next     = len_reg;
        cs_next      = cs_reg;
        tx_byte_next = tx_byte_reg;
        busy_next    = busy_reg;
        tx_dv_next   = 1'b0;
        rd_en_next   = 1'b0;
        done_next    = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                busy_next = 1'b0;
                if (start) begin
                    state_next   = ST_LOAD_HDR;
                    busy_next    = 1'b1;
                    addr_next    = base_addr;
                    remain_next  = length;
                    len_next     = length;
                    cs_next      = 8'h00;
                    hdr_idx_next = 2'd0;
                end
            end
            ST_LOAD_HDR: begin
                tx_byte_next = hdr_byte;
                kind_next    = KIND_HDR;
                state_next   = ST_ISSUE;
            end
            ST_ISSUE: begin
                tx_dv_next = 1'b1;
                state_next = ST_WAIT;
            end
            ST_WAIT: begin
                if (tx_complete) begin
                    if (kind_reg == KIND_CS) begin
                        state_next = ST_FINISH;
                    end else if (kind_reg == KIND_HDR && hdr_idx_reg != 2'd2) begin
                        hdr_idx_next = hdr_idx_reg + 2'd1;
                        state_next   = ST_LOAD_HDR;
                    end else if (remain_reg != '0) begin
                        // Read strobe is registered so it is high exactly during FETCH.
                        rd_en_next = 1'b1;
                        state_next = ST_FETCH;
                    end else begin
                        state_next = ST_LOAD_CS;
                    end
                end
            end
            ST_FETCH: begin
                state_next = ST_RDWAIT;
            end
            ST_RDWAIT: begin
                tx_byte_next = mem_rdata;
                cs_next      = cs_reg + mem_rdata;
                addr_next    = addr_reg + ADDR_W'(1);
                remain_next  = remain_reg - ADDR_W'(1);
                kind_next    = KIND_DATA;
                state_next   = ST_ISSUE;
            end
            ST_LOAD_CS: begin
                tx_byte_next = cs_reg;
                kind_next    = KIND_CS;
                state_next   = ST_ISSUE;
            end
            ST_FINISH: begin
                done_next  = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock) begin
        if (reset) begin
            state_reg        <= ST_IDLE;
            kind_reg         <= KIND_HDR;
            hdr_idx_reg      <= 2'd0;
            addr_reg         <= '0;
            remain_reg       <= '0;
            len_reg          <= '0;
            cs_reg           <= 8'h00;
            tx_byte_reg      <= 8'h00;
            tx_dv_reg        <= 1'b0;
            rd_en_reg        <= 1'b0;
            busy_reg         <= 1'b0;
            done_reg         <= 1'b0;
            tx_done_prev_reg <= 1'b0;
        end else begin
            state_reg        <= state_next;
            kind_reg         <= kind_next;
            hdr_idx_reg      <= hdr_idx_next;
            addr_reg         <= addr_next;
            remain_reg       <= remain_next;
            len_reg          <= len_next;
            cs_reg           <= cs_next;
            tx_byte_reg      <= tx_byte_next;
            tx_dv_reg        <= tx_dv_next;
            rd_en_reg        <= rd_en_next;
            busy_reg         <= busy_next;
            done_reg         <= done_next;
            tx_done_prev_reg <= Tx_Done;
        end
    end

    assign mem_addr  = addr_reg;
    assign mem_rd_en = rd_en_reg;
    assign Tx_DV     = tx_dv_reg;
    assign Tx_Byte   = tx_byte_reg;
    assign busy      = busy_reg;
    assign done      = done_reg;
    assign checksum  = cs_reg;

endmodule

// File: tb/tb_uart_frame_tx_ctrl.sv
// Bench for uart_frame_tx_ctrl: BRAM and UART transmitter models, a frame-level
// reference model, a vector table, random frames and hand-written corner cases.
module tb_uart_frame_tx_ctrl;

    logic        Clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [15:0] base_addr = 16'h0;
    logic [15:0] length = 16'h0;
    logic [15:0] mem_addr;
    logic        mem_rd_en;
    logic [7:0]  mem_rdata = 8'h00;
    logic        Tx_DV;
    logic [7:0]  Tx_Byte;
    logic        Tx_Active;
    logic        Tx_Done;
    logic        busy;
    logic        done;
    logic [7:0]  checksum;

    // Second instance with a 4-bit address space for the wrap case
    logic       w_start = 1'b0;
    logic [3:0] w_base = 4'h0;
    logic [3:0] w_len = 4'h0;
    logic [3:0] w_mem_addr;
    logic       w_rd_en;
    logic [7:0] w_rdata = 8'h00;
    logic       w_dv;
    logic [7:0] w_byte;
    logic       w_active;
    logic       w_txdone;
    logic       w_busy;
    logic       w_done;
    logic [7:0] w_cs;

    int checks = 0;
    int errors = 0;

    always #5 Clock = ~Clock;

    uart_frame_tx_ctrl #(.ADDR_W(16), .SYNC_BYTE(8'hA5)) dut (
        .Clock(Clock), .reset(reset), .start(start), .base_addr(base_addr),
        .length(length), .mem_addr(mem_addr), .mem_rd_en(mem_rd_en),
        .mem_rdata(mem_rdata), .Tx_DV(Tx_DV), .Tx_Byte(Tx_Byte),
        .Tx_Active(Tx_Active), .Tx_Done(Tx_Done), .busy(busy), .done(done),
        .checksum(checksum)
    );

    uart_frame_tx_ctrl #(.ADDR_W(4), .SYNC_BYTE(8'hA5)) dut4 (
        .Clock(Clock), .reset(reset), .start(w_start), .base_addr(w_base),
        .length(w_len), .mem_addr(w_mem_addr), .mem_rd_en(w_rd_en),
        .mem_rdata(w_rdata), .Tx_DV(w_dv), .Tx_Byte(w_byte),
        .Tx_Active(w_active), .Tx_Done(w_txdone), .busy(w_busy), .done(w_done),
        .checksum(w_cs)
    );

    // Memories with one-cycle registered read
    logic [7:0] mem  [0:65535];
    logic [7:0] mem4 [0:15];
    always @(posedge Clock) if (mem_rd_en) mem_rdata <= mem[mem_addr];
    always @(posedge Clock) if (w_rd_en)   w_rdata   <= mem4[w_mem_addr];

    // UART transmitter model: random busy time, then Tx_Done high for two cycles
    int unsigned busy_cnt = 0;
    int unsigned done_cnt = 0;
    logic [7:0]  hold_byte = 8'h00;
    int          stab_err = 0;
    assign Tx_Done   = (done_cnt != 0);
    assign Tx_Active = (busy_cnt != 0);
    always @(posedge Clock) begin
        if (reset) begin
            busy_cnt <= 0;
            done_cnt <= 0;
        end else begin
            if (busy_cnt != 0 && Tx_Byte != hold_byte) stab_err <= stab_err + 1;
            if (done_cnt != 0) done_cnt <= done_cnt - 1;
            if (Tx_DV) begin
                hold_byte <= Tx_Byte;
                busy_cnt  <= $urandom_range(6, 2);
            end else if (busy_cnt != 0) begin
                busy_cnt <= busy_cnt - 1;
                if (busy_cnt == 1) done_cnt <= 2;
            end
        end
    end

    int w_cnt = 0;
    assign w_txdone = (w_cnt == 2) || (w_cnt == 1);
    assign w_active = (w_cnt > 2);
    always @(posedge Clock) begin
        if (reset)            w_cnt <= 0;
        else if (w_dv)        w_cnt <= 5;
        else if (w_cnt != 0)  w_cnt <= w_cnt - 1;
    end

    // Monitors keep monotonic totals; the test works with snapshots of them
    logic [7:0] tx_log [0:4095];
    int dv_total = 0;
    int done_total = 0;
    int rd_total = 0;
    always @(posedge Clock) begin
        if (Tx_DV) begin
            tx_log[dv_total % 4096] <= Tx_Byte;
            dv_total <= dv_total + 1;
        end
        if (done)      done_total <= done_total + 1;
        if (mem_rd_en) rd_total   <= rd_total + 1;
    end

    logic [7:0] w_tx_log [0:15];
    logic [3:0] w_rd_log [0:15];
    int w_tx_n = 0;
    int w_rd_n = 0;
    always @(posedge Clock) begin
        if (w_dv) begin
            w_tx_log[w_tx_n % 16] <= w_byte;
            w_tx_n <= w_tx_n + 1;
        end
        if (w_rd_en) begin
            w_rd_log[w_rd_n % 16] <= w_mem_addr;
            w_rd_n <= w_rd_n + 1;
        end
    end

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: the frame as a byte list built straight from the framing rules
    logic [7:0] exp_q [$];
    task automatic model_frame(input logic [15:0] base, input logic [15:0] len);
        logic [7:0]  sum;
        logic [15:0] a;
        exp_q.delete();
        exp_q.push_back(8'hA5);
        exp_q.push_back(len[15:8]);
        exp_q.push_back(len[7:0]);
        sum = 8'h00;
        for (int i = 0; i < int'(len); i++) begin
            a = base + 16'(i);
            exp_q.push_back(mem[a]);
            sum = sum + mem[a];
        end
        exp_q.push_back(sum);
    endtask

    task automatic run_frame(input logic [15:0] base, input logic [15:0] len, input bit noise,
                             output int pulses, output int dones, output int rds);
        int  snap_dv, snap_dn, snap_rd, budget, n;
        bit  seen;
        snap_dv = dv_total;
        snap_dn = done_total;
        snap_rd = rd_total;
        model_frame(base, len);
        start = 1'b1; base_addr = base; length = len;
        step();
        start = 1'b0;
        step();
        check("start_busy", busy, 1);
        check("start_sync_byte", Tx_Byte, 8'hA5);
        check("start_dv_early", Tx_DV, 0);
        step();
        check("start_dv", Tx_DV, 1);
        budget = (int'(len) + 4) * 16 + 40;
        seen = 0;
        for (int c = 0; c < budget; c++) begin
            step();
            if (done) begin
                seen = 1;
                break;
            end
            if (noise) begin
                start     = (c % 3 == 0);
                base_addr = 16'($urandom);
                length    = 16'($urandom_range(7, 0));
            end
        end
        start = 1'b0;
        check("done_seen", seen, 1);
        check("busy_with_done", busy, 1);
        step();
        check("done_one_cycle", done, 0);
        check("busy_falls_with_done", busy, 0);
        step();
        pulses = dv_total - snap_dv;
        dones  = done_total - snap_dn;
        rds    = rd_total - snap_rd;
        check("pulse_count", pulses, exp_q.size());
        check("done_count", dones, 1);
        check("read_count", rds, int'(len));
        check("checksum_out", checksum, exp_q[exp_q.size() - 1]);
        n = (pulses < exp_q.size()) ? pulses : exp_q.size();
        for (int i = 0; i < n; i++)
            check($sformatf("frame_byte%0d", i), tx_log[(snap_dv + i) % 4096], exp_q[i]);
        $display("frame base=%04h len=%0d pulses=%0d checksum=%02h", base, len, pulses, checksum);
    endtask

    typedef struct {
        logic [15:0] base;
        logic [15:0] len;
        logic [31:0] data;      // payload bytes, first byte in [7:0]
        logic [7:0]  exp_cs;
        int          exp_pulses;
    } vec_t;

    vec_t vecs [4];

    initial begin
        int pulses, dones, rds, snap_dv, snap_dn;
        bit hit;
        logic [15:0] a;
        logic [7:0]  w_exp [6];

        vecs[0] = '{base: 16'h0010, len: 16'd3, data: 32'h0003_0201, exp_cs: 8'h06, exp_pulses: 7};
        vecs[1] = '{base: 16'h0040, len: 16'd0, data: 32'h0,         exp_cs: 8'h00, exp_pulses: 4};
        vecs[2] = '{base: 16'h0200, len: 16'd2, data: 32'h0000_02FF, exp_cs: 8'h01, exp_pulses: 6};
        vecs[3] = '{base: 16'hFFFE, len: 16'd4, data: 32'hF030_2010, exp_cs: 8'h50, exp_pulses: 8};

        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);

        repeat (3) step();
        check("rst_tx_dv", Tx_DV, 0);
        check("rst_tx_byte", Tx_Byte, 8'h00);
        check("rst_rd_en", mem_rd_en, 0);
        check("rst_mem_addr", mem_addr, 16'h0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_checksum", checksum, 8'h00);
        reset = 1'b0;
        step();

        for (int v = 0; v < 4; v++) begin
            for (int j = 0; j < int'(vecs[v].len); j++) begin
                a = vecs[v].base + 16'(j);
                mem[a] = vecs[v].data[8*j +: 8];
            end
            run_frame(vecs[v].base, vecs[v].len, 1'b0, pulses, dones, rds);
            check("tbl_checksum", checksum, vecs[v].exp_cs);
            check("tbl_pulses", pulses, vecs[v].exp_pulses);
            check("tbl_reads", rds, int'(vecs[v].len));
        end

        for (int r = 0; r < 8; r++)
            run_frame(16'($urandom), 16'($urandom_range(20, 0)), 1'b0, pulses, dones, rds);

        // start pulses and base_addr changes while busy must not disturb the frame
        run_frame(16'h0100, 16'd5, 1'b1, pulses, dones, rds);

        // Reset while the second payload byte is being transmitted
        snap_dv = dv_total;
        start = 1'b1; base_addr = 16'h0300; length = 16'd4;
        step();
        start = 1'b0;
        hit = 0;
        for (int c = 0; c < 400; c++) begin
            step();
            if (dv_total - snap_dv >= 5) begin
                hit = 1;
                break;
            end
        end
        check("reach_2nd_payload", hit, 1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("abort_tx_dv", Tx_DV, 0);
        check("abort_tx_byte", Tx_Byte, 8'h00);
        check("abort_rd_en", mem_rd_en, 0);
        check("abort_mem_addr", mem_addr, 16'h0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_checksum", checksum, 8'h00);
        snap_dv = dv_total;
        snap_dn = done_total;
        repeat (40) step();
        check("abort_no_dv", dv_total - snap_dv, 0);
        check("abort_no_done", done_total - snap_dn, 0);
        run_frame(16'h0300, 16'd4, 1'b0, pulses, dones, rds);

        // 4-bit address space: payload read wraps from 0xF to 0x0
        mem4[15] = 8'h11;
        mem4[0]  = 8'h22;
        w_exp[0] = 8'hA5; w_exp[1] = 8'h00; w_exp[2] = 8'h02;
        w_exp[3] = 8'h11; w_exp[4] = 8'h22; w_exp[5] = 8'h33;
        w_start = 1'b1; w_base = 4'hF; w_len = 4'd2;
        step();
        w_start = 1'b0;
        hit = 0;
        for (int c = 0; c < 300; c++) begin
            step();
            if (w_done) begin
                hit = 1;
                break;
            end
        end
        check("wrap_done_seen", hit, 1);
        step();
        check("wrap_reads", w_rd_n, 2);
        check("wrap_addr0", w_rd_log[0], 4'hF);
        check("wrap_addr1", w_rd_log[1], 4'h0);
        check("wrap_pulses", w_tx_n, 6);
        for (int i = 0; i < 6; i++)
            check($sformatf("wrap_byte%0d", i), w_tx_log[i], w_exp[i]);
        check("wrap_checksum", w_cs, 8'h33);
        $display("frame ADDR_W=4 base=F len=2 pulses=%0d checksum=%02h", w_tx_n, w_cs);

        check("tx_byte_stable", stab_err, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
